// File: rtl/zacore_scoreboard_if.sv
// Decode/writeback handshake bundle for the register-hazard scoreboard.
// The master side is decode plus writeback; the slave side is the scoreboard.
interface zacore_scoreboard_if #(
  parameter int REG_IDX_W = 5,
  parameter int OUT_W     = 8
);
  logic                 i_issue_valid;
  logic [REG_IDX_W-1:0] i_issue_rs1;
  logic                 i_issue_rs1_used;
  logic [REG_IDX_W-1:0] i_issue_rs2;
  logic                 i_issue_rs2_used;
  logic [REG_IDX_W-1:0] i_issue_rd;
  logic                 i_issue_rd_used;
  logic                 i_stall;
  logic                 o_issue_stall;
  logic                 i_wb_valid;
  logic [REG_IDX_W-1:0] i_wb_rd;
  logic                 i_invalidate;
  logic                 o_busy;
  logic [OUT_W-1:0]     o_outstanding;
  logic                 o_err;

  modport master (
    output i_issue_valid, i_issue_rs1, i_issue_rs1_used, i_issue_rs2,
           i_issue_rs2_used, i_issue_rd, i_issue_rd_used, i_stall,
           i_wb_valid, i_wb_rd, i_invalidate,
    input  o_issue_stall, o_busy, o_outstanding, o_err
  );

  modport slave (
    input  i_issue_valid, i_issue_rs1, i_issue_rs1_used, i_issue_rs2,
           i_issue_rs2_used, i_issue_rd, i_issue_rd_used, i_stall,
           i_wb_valid, i_wb_rd, i_invalidate,
    output o_issue_stall, o_busy, o_outstanding, o_err
  );
endinterface

// File: rtl/zacore_scoreboard.sv
// Register-hazard scoreboard and issue controller for the Zacore decode stage.
// Tracks pending destination writes per register, raises a combinational
// stall on RAW hazards or counter saturation, and holds decode after an
// invalidate until every in-flight write has retired.

// Per-register pending-write counter. Callers guarantee inc never hits a
// saturated counter and dec never hits an empty one.
module zacore_scoreboard_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);
  // Simultaneous inc and dec cancel out.
  always_ff @(posedge i_clk) begin
    if (i_rst)               o_cnt <= '0;
    else if (i_inc && !i_dec) o_cnt <= o_cnt + 1'b1;
    else if (i_dec && !i_inc) o_cnt <= o_cnt - 1'b1;
  end
endmodule

module zacore_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 2,
  parameter int OUT_W     = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  zacore_scoreboard_if.slave  sb
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  // Entry 0 is tied to zero so r0 never looks busy or saturated.
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [OUT_W-1:0]               total, total_nxt;
  logic [0:0]                     fsm;
  logic                           err, busy;

  logic rs1_haz, rs2_haz, rd_sat, haz;
  logic fire, inc, wb_hit, dec, err_set;

  assign cnt[0] = '0;

  // Hazards use registered counts only: a retire this cycle does not
  // release a stall until the next cycle.
  assign rs1_haz = sb.i_issue_rs1_used && (sb.i_issue_rs1 != '0) &&
                   (cnt[sb.i_issue_rs1] != '0);
  assign rs2_haz = sb.i_issue_rs2_used && (sb.i_issue_rs2 != '0) &&
                   (cnt[sb.i_issue_rs2] != '0);
  assign rd_sat  = sb.i_issue_rd_used && (sb.i_issue_rd != '0) &&
                   (&cnt[sb.i_issue_rd]);
  assign haz     = rs1_haz | rs2_haz | rd_sat;

  // Invalidate blocks the issue in its own cycle, before the FSM reacts.
  assign sb.o_issue_stall = sb.i_issue_valid &
                            (haz | (fsm == DRAIN) | sb.i_invalidate);

  assign fire    = sb.i_issue_valid & ~sb.o_issue_stall & ~sb.i_stall;
  assign inc     = fire & sb.i_issue_rd_used & (sb.i_issue_rd != '0);
  assign wb_hit  = sb.i_wb_valid & (sb.i_wb_rd != '0);
  assign dec     = wb_hit & (cnt[sb.i_wb_rd] != '0);
  assign err_set = wb_hit & (cnt[sb.i_wb_rd] == '0);

  // One counter per architectural register except r0.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    zacore_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (inc && (sb.i_issue_rd == REG_IDX_W'(g))),
      .i_dec (dec && (sb.i_wb_rd == REG_IDX_W'(g))),
      .o_cnt (cnt[g])
    );
  end

  // Next total: issue and retire in the same cycle cancel.
  always_comb begin
    total_nxt = total;
    case ({inc, dec})
      2'b10:   total_nxt = total + 1'b1;
      2'b01:   total_nxt = total - 1'b1;
      default: total_nxt = total;
    endcase
  end

  // Outstanding count and its nonzero flag, both registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      total <= '0;
      busy  <= 1'b0;
    end else begin
      total <= total_nxt;
      busy  <= (total_nxt != '0);
    end
  end

  // Sticky error on a retire to a register with nothing pending.
  always_ff @(posedge i_clk) begin
    if (i_rst)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Recovery sequencing: leave DRAIN only once nothing is in flight and
  // no new invalidate is arriving.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm <= RUN;
    end else begin
      case (fsm)
        RUN:     if (sb.i_invalidate) fsm <= DRAIN;
        DRAIN:   if (!sb.i_invalidate && (total == '0)) fsm <= RUN;
        default: fsm <= RUN;
      endcase
    end
  end

  assign sb.o_busy        = busy;
  assign sb.o_outstanding = total;
  assign sb.o_err         = err;
endmodule
